// File: rtl/bitfusion_sched_pkg.sv
// rtl/bitfusion_sched_pkg.sv - precision codes, FSM states, job config and beat helpers for bitfusion_sched
package bitfusion_pkg;

    localparam logic [2:0] PREC_2B = 3'b001;
    localparam logic [2:0] PREC_4B = 3'b010;
    localparam logic [2:0] PREC_8B = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic       clear_first;
        logic [7:0] num_words;
        logic [2:0] in_bw;
        logic [2:0] wt_bw;
    } job_cfg_t;

    function automatic logic code_valid(input logic [2:0] code);
        return (code == PREC_2B) || (code == PREC_4B) || (code == PREC_8B);
    endfunction

    // An 8-bit operand on either side needs two beats to stream one buffer word.
    function automatic logic [1:0] beats_per_word(input logic [2:0] in_code, input logic [2:0] wt_code);
        return ((in_code == PREC_8B) || (wt_code == PREC_8B)) ? 2'd2 : 2'd1;
    endfunction

    function automatic logic [8:0] stream_len(input job_cfg_t cfg);
        return (beats_per_word(cfg.in_bw, cfg.wt_bw) == 2'd2) ? {cfg.num_words, 1'b0}
                                                               : {1'b0, cfg.num_words};
    endfunction

endpackage

// File: rtl/bitfusion_sched_if.sv
// rtl/bitfusion_sched_if.sv - job request and array enable bundle between host and scheduler
interface bitfusion_sched_if #(
    parameter int ARRAY_SIZE = 2
);

    logic                                 start;
    logic                                 clear_first;
    logic [7:0]                           num_words;
    logic [2:0]                           input_bitwidth;
    logic [2:0]                           weight_bitwidth;
    logic [ARRAY_SIZE-1:0]                input_rd_en;
    logic [ARRAY_SIZE-1:0][ARRAY_SIZE-1:0] weight_rd_en;
    logic [ARRAY_SIZE-1:0]                acc_clear;
    logic                                 busy;
    logic                                 done;
    logic                                 cfg_err;

    modport master (
        output start, clear_first, num_words, input_bitwidth, weight_bitwidth,
        input  input_rd_en, weight_rd_en, acc_clear, busy, done, cfg_err
    );

    modport slave (
        input  start, clear_first, num_words, input_bitwidth, weight_bitwidth,
        output input_rd_en, weight_rd_en, acc_clear, busy, done, cfg_err
    );

endinterface

// File: rtl/bitfusion_sched.sv
// rtl/bitfusion_sched.sv - diagonal-wavefront enable scheduler for an NxN bit-fusion array
// Optional BITFUSION_SCHED_PERF_EN adds perf_cycles (busy cycles of the last completed job).
module bitfusion_sched
    import bitfusion_pkg::*;
#(
    parameter int ARRAY_SIZE   = 2,
    parameter int DATA_W       = 32,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic             clk,
    input  logic             nRST,
    bitfusion_sched_if.slave bus
`ifdef BITFUSION_SCHED_PERF_EN
    ,
    output logic [31:0]      perf_cycles
`endif
);

    localparam int N     = ARRAY_SIZE;
    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] SKEW       = CNT_W'(2 * (N - 1));
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

    if (N < 1 || DATA_W < 1 || DRAIN_CYCLES < 1) begin : g_param_check
        $error("bitfusion_sched: ARRAY_SIZE, DATA_W and DRAIN_CYCLES must all be at least 1");
    end

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    job_cfg_t             cfg_q, cfg_d, cfg_in;
    logic                 accept, reject;
    logic [CNT_W-1:0]     len_d;
    logic [CNT_W-1:0]     run_last;
    logic [N-1:0]         in_en_d, in_en_q;
    logic [N-1:0]         clr_d, clr_q;
    logic [N-1:0][N-1:0]  wt_en_d, wt_en_q;
    logic                 busy_q, done_q, cfg_err_q;

    // cfg_d is the configuration of the job that state_d belongs to, so the
    // registered enables for the first RUN cycle already see the new length.
    always_comb begin
        cfg_in.clear_first = bus.clear_first;
        cfg_in.num_words   = bus.num_words;
        cfg_in.in_bw       = bus.input_bitwidth;
        cfg_in.wt_bw       = bus.weight_bitwidth;

        accept   = 1'b0;
        reject   = 1'b0;
        if ((state_q == ST_IDLE) && bus.start) begin
            if (code_valid(bus.input_bitwidth) && code_valid(bus.weight_bitwidth)) begin
                accept = 1'b1;
            end else begin
                reject = 1'b1;
            end
        end

        cfg_d    = accept ? cfg_in : cfg_q;
        len_d    = CNT_W'(stream_len(cfg_d));
        run_last = len_d + SKEW - CNT_W'(1);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    cnt_d = '0;
                    if (cfg_d.clear_first) begin
                        state_d = ST_CLEAR;
                    end else if (len_d == '0) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_CLEAR: begin
                cnt_d   = '0;
                state_d = (len_d == '0) ? ST_DRAIN : ST_RUN;
            end
            ST_RUN: begin
                if (cnt_q == run_last) begin
                    state_d = ST_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Window test lo <= t < lo+L done as (t - lo) < L: when t < lo the
    // subtraction wraps far above any legal L, so one unsigned compare suffices.
    for (genvar r = 0; r < N; r++) begin : g_row
        localparam logic [CNT_W-1:0] ROW_OFS = CNT_W'(r);
        assign in_en_d[r] = (state_d == ST_RUN) && ((cnt_d - ROW_OFS) < len_d);
        for (genvar c = 0; c < N; c++) begin : g_col
            localparam logic [CNT_W-1:0] DIAG_OFS = CNT_W'(r + c);
            assign wt_en_d[r][c] = (state_d == ST_RUN) && ((cnt_d - DIAG_OFS) < len_d);
        end
    end

    assign clr_d = {N{state_d == ST_CLEAR}};

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            cfg_q     <= '0;
            in_en_q   <= '0;
            wt_en_q   <= '0;
            clr_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cfg_q     <= cfg_d;
            in_en_q   <= in_en_d;
            wt_en_q   <= wt_en_d;
            clr_q     <= clr_d;
            busy_q    <= (state_d != ST_IDLE);
            done_q    <= (state_d == ST_DONE);
            cfg_err_q <= reject;
        end
    end

    assign bus.input_rd_en  = in_en_q;
    assign bus.weight_rd_en = wt_en_q;
    assign bus.acc_clear    = clr_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.cfg_err      = cfg_err_q;

`ifdef BITFUSION_SCHED_PERF_EN
    logic [31:0] busy_cnt_q;
    logic [31:0] perf_q;

    // Captured as DONE is entered so the count is visible alongside done;
    // +2 covers the current last DRAIN cycle and the DONE cycle itself.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            busy_cnt_q <= '0;
            perf_q     <= '0;
        end else begin
            if (state_q == ST_IDLE) begin
                busy_cnt_q <= '0;
            end else begin
                busy_cnt_q <= busy_cnt_q + 32'd1;
            end
            if (state_d == ST_DONE) begin
                perf_q <= busy_cnt_q + 32'd2;
            end
        end
    end

    assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_bitfusion_sched.sv
// tb/tb_bitfusion_sched.sv - randomized self-checking bench for bitfusion_sched against a schedule model
module tb_bitfusion_sched;

    localparam int N     = 2;
    localparam int DRAIN = 4;
    localparam int VW    = 3 + 2 * N + N * N;

    logic clk = 1'b0;
    logic nRST;
    int   n_checks = 0;
    int   n_fail   = 0;

    bitfusion_sched_if #(.ARRAY_SIZE(N)) bus ();

`ifdef BITFUSION_SCHED_PERF_EN
    logic [31:0] perf_cycles;
`endif

    bitfusion_sched #(
        .ARRAY_SIZE  (N),
        .DATA_W      (32),
        .DRAIN_CYCLES(DRAIN)
    ) dut (
        .clk (clk),
        .nRST(nRST),
        .bus (bus)
`ifdef BITFUSION_SCHED_PERF_EN
        ,
        .perf_cycles(perf_cycles)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [VW-1:0] observed();
        return {bus.busy, bus.done, bus.cfg_err, bus.acc_clear, bus.input_rd_en, bus.weight_rd_en};
    endfunction

    // Expected outputs k cycles after the accepting edge, from the job timeline:
    // optional CLEAR, RUN of L+2(N-1) cycles (skipped when L=0), DRAIN, DONE.
    function automatic logic [VW-1:0] model(int k, bit clr, int len);
        int k0, run, last, t;
        logic [N-1:0]        acc;
        logic [N-1:0]        in_en;
        logic [N-1:0][N-1:0] wt;
        logic                busy, done;
        k0    = clr ? 1 : 0;
        run   = (len > 0) ? len + 2 * (N - 1) : 0;
        last  = k0 + run + DRAIN;
        acc   = '0;
        in_en = '0;
        wt    = '0;
        busy  = (k >= 0) && (k <= last);
        done  = (k == last);
        if (clr && k == 0) acc = '1;
        if (k >= k0 && k < k0 + run) begin
            t = k - k0;
            for (int r = 0; r < N; r++) begin
                in_en[r] = (t >= r) && (t < r + len);
                for (int c = 0; c < N; c++) begin
                    wt[r][c] = (t >= r + c) && (t < r + c + len);
                end
            end
        end
        return {busy, done, 1'b0, acc, in_en, wt};
    endfunction

    task automatic idle_inputs();
        bus.start           = 1'b0;
        bus.clear_first     = 1'b0;
        bus.num_words       = 8'd0;
        bus.input_bitwidth  = 3'b001;
        bus.weight_bitwidth = 3'b001;
    endtask

    task automatic run_job(input string name, input bit clr, input int nw, input logic [2:0] ib,
                           input logic [2:0] wb, input bit noisy, input bit align);
        int len, last;
        logic [VW-1:0] exp_v, obs_v;
        len  = nw * (((ib == 3'b100) || (wb == 3'b100)) ? 2 : 1);
        last = (clr ? 1 : 0) + ((len > 0) ? len + 2 * (N - 1) : 0) + DRAIN;
        if (align) @(negedge clk);
        bus.start           = 1'b1;
        bus.clear_first     = clr;
        bus.num_words       = nw[7:0];
        bus.input_bitwidth  = ib;
        bus.weight_bitwidth = wb;
        @(posedge clk);
        #1;
        for (int k = 0; k <= last + 1; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            exp_v = model(k, clr, len);
            obs_v = observed();
            n_checks++;
            if (obs_v !== exp_v) begin
                n_fail++;
                $display("FAIL %s k=%0d {busy,done,cfg_err,acc_clear,in_en,wt_en}: got %b expected %b",
                         name, k, obs_v, exp_v);
            end
            if (noisy && k < last) begin
                bus.start           = 1'($urandom_range(0, 1));
                bus.clear_first     = 1'($urandom_range(0, 1));
                bus.num_words       = 8'($urandom);
                bus.input_bitwidth  = 3'($urandom);
                bus.weight_bitwidth = 3'($urandom);
            end else begin
                bus.start = 1'b0;
            end
        end
`ifdef BITFUSION_SCHED_PERF_EN
        n_checks++;
        if (perf_cycles !== 32'(last + 1)) begin
            n_fail++;
            $display("FAIL %s perf_cycles: got %0d expected %0d", name, perf_cycles, last + 1);
        end
`endif
        idle_inputs();
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (observed() !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected all zero", observed());
        end
`ifdef BITFUSION_SCHED_PERF_EN
        n_checks++;
        if (perf_cycles !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_perf: got %0d expected 0", perf_cycles);
        end
`endif
        @(negedge clk);
        nRST = 1'b1;
        run_job("first_start", 1'b0, 1, 3'b100, 3'b010, 1'b0, 1'b0);
    endtask

    task automatic test_directed();
        run_job("i8_w4_nw1", 1'b0, 1, 3'b100, 3'b010, 1'b0, 1'b1);
        run_job("i2_w2_nw3_clr", 1'b1, 3, 3'b001, 3'b001, 1'b0, 1'b1);
        run_job("nw0", 1'b0, 0, 3'b010, 3'b100, 1'b0, 1'b1);
        run_job("nw0_clr", 1'b1, 0, 3'b001, 3'b010, 1'b0, 1'b1);
        run_job("w8_nw255", 1'b0, 255, 3'b001, 3'b100, 1'b0, 1'b1);
    endtask

    task automatic test_cfg_err();
        logic [2:0] bad [5];
        logic [2:0] good [3];
        logic [2:0] ib, wb;
        logic [VW-1:0] exp_err;
        bad  = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};
        good = '{3'b001, 3'b010, 3'b100};
        exp_err = '0;
        exp_err[VW-3] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i == 0) begin
                ib = 3'b011;
                wb = 3'b010;
            end else if ($urandom_range(0, 1) == 1) begin
                ib = bad[$urandom_range(0, 4)];
                wb = good[$urandom_range(0, 2)];
            end else begin
                ib = good[$urandom_range(0, 2)];
                wb = bad[$urandom_range(0, 4)];
            end
            @(negedge clk);
            bus.start           = 1'b1;
            bus.clear_first     = 1'($urandom_range(0, 1));
            bus.num_words       = 8'($urandom_range(1, 5));
            bus.input_bitwidth  = ib;
            bus.weight_bitwidth = wb;
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            n_checks++;
            if (observed() !== exp_err) begin
                n_fail++;
                $display("FAIL cfg_err_pulse ib=%b wb=%b: got %b expected %b", ib, wb, observed(), exp_err);
            end
            @(posedge clk);
            #1;
            n_checks++;
            if (observed() !== '0) begin
                n_fail++;
                $display("FAIL cfg_err_stays_idle ib=%b wb=%b: got %b expected all zero", ib, wb, observed());
            end
        end
        idle_inputs();
        run_job("after_cfg_err", 1'b0, 2, 3'b010, 3'b010, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid_job();
        @(negedge clk);
        bus.start           = 1'b1;
        bus.clear_first     = 1'b0;
        bus.num_words       = 8'd1;
        bus.input_bitwidth  = 3'b100;
        bus.weight_bitwidth = 3'b010;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (observed() !== model(1, 1'b0, 2)) begin
            n_fail++;
            $display("FAIL pre_reset_t1: got %b expected %b", observed(), model(1, 1'b0, 2));
        end
        #2;
        nRST = 1'b0;
        #1;
        n_checks++;
        if (observed() !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_job: got %b expected all zero", observed());
        end
        idle_inputs();
        @(negedge clk);
        nRST = 1'b1;
        run_job("after_reset_i8_w4", 1'b0, 1, 3'b100, 3'b010, 1'b0, 1'b0);
        run_job("after_reset_clr", 1'b1, 2, 3'b100, 3'b100, 1'b0, 1'b1);
    endtask

    task automatic test_ignore_start();
        run_job("noisy_i8_w4_nw1", 1'b0, 1, 3'b100, 3'b010, 1'b1, 1'b1);
        run_job("noisy_i4_w2_nw4_clr", 1'b1, 4, 3'b010, 3'b001, 1'b1, 1'b1);
    endtask

    task automatic test_random();
        logic [2:0] good [3];
        good = '{3'b001, 3'b010, 3'b100};
        for (int i = 0; i < 20; i++) begin
            run_job("random", 1'($urandom_range(0, 1)), int'($urandom_range(0, 6)),
                    good[$urandom_range(0, 2)], good[$urandom_range(0, 2)],
                    1'($urandom_range(0, 1)), 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_cfg_err();
        test_reset_mid_job();
        test_ignore_start();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bitfusion_sched.md
BITFUSION_SCHED -- requirements
Module: bitfusion_sched

Interface
REQ-001 SHALL have parameter ARRAY_SIZE, default 2, systolic array rows/columns (N).
REQ-002 SHALL have parameter DATA_W, default 32, buffer word width in bits.
REQ-003 SHALL have parameter DRAIN_CYCLES, default 4, idle cycles after the last enable before done.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port nRST  input  1  asynchronous active-low reset.
REQ-006 SHALL have port start  input  1  job request, sampled in IDLE only.
REQ-007 SHALL have port clear_first  input  1  pulse acc_clear before streaming, sampled with start.
REQ-008 SHALL have port num_words  input  8  DATA_W-bit words per row stream, sampled with start.
REQ-009 SHALL have ports input_bitwidth, weight_bitwidth  input  3 each  precision codes (001=2b, 010=4b, 100=8b), sampled with start.
REQ-010 SHALL have port input_rd_en  output  N  per-row input enable to the array.
REQ-011 SHALL have port weight_rd_en  output  N x N  per-unit weight enable, indexed [row][col].
REQ-012 SHALL have port acc_clear  output  N  per-row accumulator clear.
REQ-013 SHALL have port busy  output  1  high in every non-IDLE state.
REQ-014 SHALL have port done  output  1  one-cycle completion pulse.
REQ-015 SHALL have port cfg_err  output  1  one-cycle pulse on a rejected start.

Function
REQ-016 SHALL implement states IDLE, CLEAR, RUN, DRAIN, DONE.
REQ-017 IDLE + start + valid codes SHALL latch num_words, both bitwidths and clear_first, then go to CLEAR if clear_first else RUN.
REQ-018 Any code not in {001,010,100} at start SHALL pulse cfg_err for one cycle and stay in IDLE.
REQ-019 Beats per word B SHALL be 2 if either latched code is 100, else 1; stream length L = num_words*B, computed at full width with no truncation.
REQ-020 CLEAR SHALL last exactly one cycle with acc_clear all-ones, then go to RUN; acc_clear SHALL be 0 in every other state.
REQ-021 RUN cycle t (first RUN cycle t=0) SHALL drive weight_rd_en[r][c]=1 iff r+c <= t <= r+c+L-1.
REQ-022 RUN cycle t SHALL drive input_rd_en[r]=1 iff r <= t <= r+L-1.
REQ-023 RUN SHALL last L+2(N-1) cycles, then go to DRAIN; enables SHALL be 0 outside RUN.
REQ-024 L=0 SHALL skip RUN entirely, going to DRAIN with no enable asserted.
REQ-025 DRAIN SHALL last DRAIN_CYCLES cycles, then DONE; DONE SHALL assert done for one cycle and return to IDLE.
REQ-026 start in a non-IDLE state SHALL be ignored, with no effect on the latched config.
REQ-027 Changes to the config inputs after acceptance SHALL not affect the running job.
REQ-028 All outputs SHALL be registered.

Reset
REQ-029 nRST low SHALL immediately force state IDLE and drive all enables, acc_clear, busy, done and cfg_err to 0, including mid-job.
REQ-030 The first start is accepted on the first rising edge with nRST high.

Configuration
REQ-031 With macro BITFUSION_SCHED_PERF_EN defined, the block SHALL add output perf_cycles (32 bits): busy cycles of the last completed job, updated on done and reset to 0.
REQ-032 Without BITFUSION_SCHED_PERF_EN, the port and its counter SHALL not exist.

Structure
REQ-033 Package bitfusion_pkg SHALL hold the precision code constants, the state enum, and a beats-per-word function.
REQ-034 The block SHALL be one module with no sub-module; the window compare is a generate loop over [r][c].

Verification
REQ-035 N=2, 8b input x 4b weight, num_words=1, clear_first=0 -> L=2, RUN lasts 4 cycles; input_rd_en[0] high t0-1, input_rd_en[1] high t1-2, weight_rd_en[0][0] t0-1, [0][1] and [1][0] t1-2, [1][1] t2-3; done 4 cycles after RUN ends.
REQ-036 2b x 2b, num_words=3, clear_first=1 -> acc_clear=11 for one cycle, then L=3, RUN lasts 5 cycles, busy continuous until done.
REQ-037 input_bitwidth=011 at start -> cfg_err pulses, busy stays 0, no enable asserted.
REQ-038 num_words=0 -> no enable asserted, done after exactly DRAIN_CYCLES+1 cycles of busy.
REQ-039 nRST asserted at RUN t=1 -> all outputs 0 immediately; after release, the next start runs a full job with correct windows.
REQ-040 start pulsed during RUN with different num_words -> ignored, and the original schedule completes unchanged; with PERF_EN, perf_cycles = 9 for the REQ-035 job.
